mips_mc_control: RTL

- Multicycle MIPS main control FSM. Drives the datapath and is the sole source of the ALU's aluctl code; consumes the ALU's zero flag.
- Sequences fetch/decode/execute for lw, sw, R-type (add/sub/and/or), beq, j, addi.
- Sits between instruction register (opcode/funct) and datapath muxes, PC, register file and memory enables.

---
 rtl/mips_mc_control.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_control.sv
// Main control FSM for the multicycle MIPS datapath.
// It sequences fetch, decode and execute, and it is the only source of the ALU operation code.
module mips_mc_control #(
    parameter bit ADDI_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic [2:0] aluctl,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC     = 4'd6,
        S_RTYPEWB  = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t state_q;
    state_t state_d;

    logic funct_ok;
    logic decode_ok;
    logic pcen_raw;
    logic memread_raw;
    logic memwrite_raw;
    logic irwrite_raw;
    logic regwrite_raw;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        funct_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
                   (funct == FN_AND) || (funct == FN_OR);
    end

    always_comb begin
        decode_ok = 1'b0;
        unique case (opcode)
            OP_LW, OP_SW:  decode_ok = 1'b1;
            OP_RTYPE:      decode_ok = funct_ok;
            OP_BEQ, OP_J:  decode_ok = 1'b1;
            OP_ADDI:       decode_ok = ADDI_EN;
            default:       decode_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (decode_ok) begin
                    unique case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_ADDIEXEC;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_EXEC:     state_d = S_RTYPEWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcen_raw     = 1'b0;
        iord         = 1'b0;
        memread_raw  = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_raw = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsource     = 2'b00;
        aluctl       = ALU_ADD;
        illegal      = 1'b0;
        case (state_q)
            S_FETCH: begin
                memread_raw = 1'b1;
                irwrite_raw = 1'b1;
                alusrcb     = 2'b01;
                pcen_raw    = 1'b1;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                illegal = !decode_ok;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                memread_raw = 1'b1;
                iord        = 1'b1;
            end
            S_MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            S_MEMWR: begin
                memwrite_raw = 1'b1;
                iord         = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                case (funct)
                    FN_SUB:  aluctl = ALU_SUB;
                    FN_AND:  aluctl = ALU_AND;
                    FN_OR:   aluctl = ALU_OR;
                    default: aluctl = ALU_ADD;
                endcase
            end
            S_RTYPEWB: begin
                regwrite_raw = 1'b1;
                regdst       = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b00;
                aluctl   = ALU_SUB;
                pcsource = 2'b01;
                pcen_raw = zero;
            end
            S_JUMP: begin
                pcsource = 2'b10;
                pcen_raw = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Write strobes are masked directly by rstn so that nothing is written while reset is held.
    assign pcen     = pcen_raw     & rstn;
    assign memread  = memread_raw  & rstn;
    assign memwrite = memwrite_raw & rstn;
    assign irwrite  = irwrite_raw  & rstn;
    assign regwrite = regwrite_raw & rstn;
    assign state    = state_q;

endmodule
